// File: rtl/gfx_palette_responder_if.sv
// Bus bundle for the palette responder: the two gfx fetch ports used by the
// priority evaluator and the CPU request/ack port.
// master = evaluator/CPU side (drives addresses and requests),
// slave  = palette responder (returns data and acks).
interface gfx_palette_responder_if;
    logic [31:0] gfx_palette_bg_addr;
    logic [31:0] gfx_palette_obj_addr;
    logic [31:0] gfx_palette_bg_data;
    logic [31:0] gfx_palette_obj_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;

    modport master (
        output gfx_palette_bg_addr, gfx_palette_obj_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata,
        input  gfx_palette_bg_data, gfx_palette_obj_data,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  gfx_palette_bg_addr, gfx_palette_obj_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata,
        output gfx_palette_bg_data, gfx_palette_obj_data,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/gfx_palette_responder.sv
// Palette RAM responder: two 128 x 32-bit banks (BG, OBJ), each with a
// registered 1-cycle gfx read port, plus a CPU request/ack port doing
// reads and lane-masked read-modify-write. A clear sequencer zero-fills
// both banks after reset when CLEAR_ON_RESET = 1.
// Optional macro GFX_PALETTE_BYTE_WRITE_EN: byte writes replicate the
// addressed byte into both bytes of its halfword; when undefined, byte
// writes are acked but leave memory unchanged.
module gfx_palette_responder #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     rst_b,
    gfx_palette_responder_if.slave   bus,
    output logic                     init_busy
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [6:0]  clr_cnt;

    logic [31:0] bg_mem  [128];
    logic [31:0] obj_mem [128];

    logic [6:0]  cpu_idx, bg_idx, obj_idx;
    logic [31:0] old_word;
    logic [3:0]  lane_mask;
    logic [31:0] bit_mask;
    logic [31:0] lane_data;
    logic [31:0] merged_word;

    logic        bg_we, obj_we, rd_capture;
    logic [6:0]  wr_idx;
    logic [31:0] wr_data;

    logic [31:0] bg_data_q, obj_data_q, rdata_q;
    logic [31:0] bg_fwd, obj_fwd;

    // Address bits outside the word index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.gfx_palette_bg_addr[31:9], bus.gfx_palette_bg_addr[1:0],
                                bus.gfx_palette_obj_addr[31:9], bus.gfx_palette_obj_addr[1:0],
                                bus.cpu_addr[0]};

    assign cpu_idx = bus.cpu_addr[8:2];
    assign bg_idx  = bus.gfx_palette_bg_addr[8:2];
    assign obj_idx = bus.gfx_palette_obj_addr[8:2];

    // Current contents of the CPU-addressed word, the base for RMW and reads.
    assign old_word = bus.cpu_addr[9] ? obj_mem[cpu_idx] : bg_mem[cpu_idx];

    // Lane mask and lane data for the CPU write, then merge into the old word.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = bus.cpu_wdata;
        case (bus.cpu_size)
            2'd0: begin
`ifdef GFX_PALETTE_BYTE_WRITE_EN
                lane_data = {4{bus.cpu_wdata[{bus.cpu_addr[1:0], 3'b000} +: 8]}};
                lane_mask = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
`else
                lane_mask = 4'b0000;
`endif
            end
            2'd1:    lane_mask = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        bit_mask    = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
        merged_word = (old_word & ~bit_mask) | (lane_data & bit_mask);
    end

    // FSM next state and per-cycle write/read controls.
    always_comb begin
        next_state = state;
        bg_we      = 1'b0;
        obj_we     = 1'b0;
        rd_capture = 1'b0;
        wr_idx     = cpu_idx;
        wr_data    = merged_word;
        case (state)
            CLEAR: begin
                bg_we   = 1'b1;
                obj_we  = 1'b1;
                wr_idx  = clr_cnt;
                wr_data = '0;
                if (clr_cnt == 7'd127) next_state = IDLE;
            end
            IDLE: begin
                if (bus.cpu_req) begin
                    next_state = ACK;
                    if (bus.cpu_we) begin
                        bg_we  = ~bus.cpu_addr[9];
                        obj_we = bus.cpu_addr[9];
                    end else begin
                        rd_capture = 1'b1;
                    end
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and clear counter.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) clr_cnt <= clr_cnt + 7'd1;
        end
    end

    // Bank write ports, shared by the clear sequencer and CPU RMW.
    // NOTE: memory arrays are deliberately not reset; the clear sequencer initialises them.
    always_ff @(posedge clock) begin
        if (bg_we)  bg_mem[wr_idx]  <= wr_data;
        if (obj_we) obj_mem[wr_idx] <= wr_data;
    end

    // Write-first forwarding: a same-cycle write to the fetched word wins.
    assign bg_fwd  = (bg_we  && (wr_idx == bg_idx))  ? wr_data : bg_mem[bg_idx];
    assign obj_fwd = (obj_we && (wr_idx == obj_idx)) ? wr_data : obj_mem[obj_idx];

    // Registered gfx read data and CPU read capture.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            bg_data_q  <= '0;
            obj_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            bg_data_q  <= bg_fwd;
            obj_data_q <= obj_fwd;
            if (rd_capture) rdata_q <= old_word;
        end
    end

    assign bus.gfx_palette_bg_data  = bg_data_q;
    assign bus.gfx_palette_obj_data = obj_data_q;
    assign bus.cpu_rdata            = rdata_q;
    assign bus.cpu_ack              = (state == ACK);
    assign init_busy                = (state == CLEAR);

endmodule

// File: doc/gfx_palette_responder.md
Name: gfx_palette_responder

Overview:
- Palette RAM responder serving the priority evaluator's palette fetches.
- BG and OBJ each have a 512-byte bank, held as 128 x 32-bit words.
- Two gfx read ports, one per bank, with fixed 1-cycle read latency, matching the evaluator's one-cycle-delayed bank select.
- A CPU-side request/ack port performs reads and writes.
- After reset, a clear sequencer zero-fills both banks.

Parameters:
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = skip it and go straight to IDLE (memory contents undefined).

Ports:
- clock  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- gfx_palette_bg_addr  in  32  BG byte address; word index = [8:2], other bits ignored
- gfx_palette_obj_addr  in  32  OBJ byte address; word index = [8:2], other bits ignored
- gfx_palette_bg_data  out  32  BG word, valid 1 cycle after address
- gfx_palette_obj_data  out  32  OBJ word, valid 1 cycle after address
- cpu_req  in  1  request strobe, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  10  byte address; bit 9 = bank (0 BG, 1 OBJ); [8:2] = word; [1:0] = byte lane
- cpu_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 treated as word
- cpu_wdata  in  32  write data, lane-aligned as the CPU presents it
- cpu_rdata  out  32  full read word
- cpu_ack  out  1  single-cycle completion pulse
- init_busy  out  1  high while clearing

Behaviour:
- Reset (rst_b low, asynchronous) forces:
  - state = CLEAR if CLEAR_ON_RESET = 1, else IDLE
  - clear counter = 0
  - gfx_palette_bg_data, gfx_palette_obj_data, cpu_rdata = 0
  - cpu_ack = 0
  - init_busy = CLEAR_ON_RESET
- FSM states: CLEAR, IDLE, ACK.
- CLEAR:
  - Each cycle writes 0 to word[cnt] in both banks; cnt increments 0..127.
  - At cnt = 127 the write is done and the next state is IDLE; init_busy drops on entering IDLE (128 cycles after reset release).
  - cpu_req is ignored; no ack.
  - gfx data outputs read normally, so values may be zero or stale.
- IDLE:
  - cpu_req = 1 performs the access this cycle.
  - Write: read-modify-write of the addressed word using the lane mask (below).
  - Read: captures the word into cpu_rdata.
  - Next state is ACK.
- ACK:
  - cpu_ack = 1 for exactly this cycle; next state is IDLE.
  - cpu_req is not sampled in ACK, so back-to-back requests give a 2-cycle cadence.
- Write lane mask:
  - Word: all 4 lanes, data unchanged.
  - Halfword: lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
  - Byte: see Optional Feature.
- gfx read ports:
  - Registered outputs: data[t+1] = bank[addr[8:2] at t]. The ports are independent; both may be read every cycle.
  - Read-during-write (CPU write or clear write to the same bank and word in the same cycle): the gfx output returns the post-write merged word (write-first forwarding).
- cpu_rdata holds its value until the next CPU read.
- Reset asserted mid-operation:
  - Reset in CLEAR restarts the clear from 0.
  - Reset in ACK drops the ack; the pending write may or may not have landed, and the bench does not check it.

Optional Feature:
- Macro: GFX_PALETTE_BYTE_WRITE_EN
- Defined: a byte write replicates cpu_wdata's addressed lane byte into both bytes of the containing halfword (lanes {addr[1],0} and {addr[1],1}). This is the hardware palette byte-write rule.
- Not defined: byte writes are acked normally but leave memory unchanged; byte reads behave as defined.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1:
  - init_busy is high for 128 cycles.
  - A cpu_req (read) asserted during that time gets no ack until after the clear.
  - Every BG and OBJ word then reads 0x00000000 on the gfx ports.
- CPU word write 0x7FFF001F to addr 0x204 (OBJ word 1); then gfx_palette_obj_addr = 0x04 -> gfx_palette_obj_data = 0x7FFF001F the next cycle; BG word 1 is unchanged (0).
- Halfword write 0x1234 to BG addr 0x012 over 0xAAAAAAAA -> word 4 = 0x1234AAAA; cpu_ack pulses exactly one cycle, 1 cycle after the req cycle.
- Byte write 0x5A to BG addr 0x009, word 2 = 0:
  - With GFX_PALETTE_BYTE_WRITE_EN: word 2 = 0x00005A5A.
  - Without it: word 2 = 0x00000000, and ack is still given.
- Same-cycle CPU word write 0x11223344 to BG word 7 while gfx_palette_bg_addr = 0x1C -> gfx_palette_bg_data = 0x11223344 the next cycle.
- Reset asserted at clear count 60 and released -> init_busy high for a full 128 cycles again; cpu_ack = 0 throughout.
